// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state codes,
// default sizing constants and the grant index width helper.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. Searches last+1, last+2, ... (mod NREQ)
// and returns the first requesting index. Kept generic so other shared
// resource arbiters can reuse it.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   grant,
  output logic            any_req
);

  // Walk the rotation from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        grant   = GW'((int'(last) + k) % NREQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one signed shift-add multiplier
// among NREQ requesters. Latches the winner's operands and sign mode,
// pulses m_start, waits for m_valid, captures the product and returns a
// one-cycle ack to the winner.
// Optional build macro: MULT_ARB_TIMEOUT_EN adds a BUSY watchdog that
// aborts after TIMEOUT cycles with result=0 and err=1.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int GW      = gid_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ-1:0]       sgn,
  output logic [NREQ-1:0]       ack,
  output logic [2*WIDTH-1:0]    result,
  output logic                  err,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  m_start,
  output logic                  m_sign,
  output logic [WIDTH-1:0]      m_a,
  output logic [WIDTH-1:0]      m_b,
  input  logic                  m_valid,
  input  logic [2*WIDTH-1:0]    m_product
);

  // Reject configurations the arbiter is not built for.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t               state_reg;
  logic [GW-1:0]        last_reg;
  logic [GW-1:0]        grant_reg;
  logic [NREQ-1:0]      ack_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 busy_reg;
  logic                 m_start_reg;
  logic                 m_sign_reg;
  logic [WIDTH-1:0]     m_a_reg;
  logic [WIDTH-1:0]     m_b_reg;

  logic [WIDTH-1:0]     a_slice [NREQ];
  logic [WIDTH-1:0]     b_slice [NREQ];
  logic [NREQ-1:0]      grant_onehot;
  logic [GW-1:0]        pick_id;
  logic                 pick_any;

  // Unpack per-requester operand slices and decode the owner to one-hot.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi]      = op_a[gi*WIDTH +: WIDTH];
    assign b_slice[gi]      = op_b[gi*WIDTH +: WIDTH];
    assign grant_onehot[gi] = (grant_reg == GW'(gi));
  end

  rr_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_picker (
    .req     (req),
    .last    (last_reg),
    .grant   (pick_id),
    .any_req (pick_any)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg;
  logic          err_reg;
  logic          timeout_hit;

  // Counter holds BUSY cycles already elapsed, so TIMEOUT-1 marks the last one.
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
  assign err         = err_reg;
`else
  assign err = 1'b0;
`endif

  assign ack      = ack_reg;
  assign result   = result_reg;
  assign grant_id = grant_reg;
  assign busy     = busy_reg;
  assign m_start  = m_start_reg;
  assign m_sign   = m_sign_reg;
  assign m_a      = m_a_reg;
  assign m_b      = m_b_reg;

  // Transaction sequencer: grant, issue, wait for product, acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_reg    <= GW'(NREQ - 1);
      grant_reg   <= '0;
      ack_reg     <= '0;
      result_reg  <= '0;
      busy_reg    <= 1'b0;
      m_start_reg <= 1'b0;
      m_sign_reg  <= 1'b0;
      m_a_reg     <= '0;
      m_b_reg     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg   <= pick_id;
            last_reg    <= pick_id;
            m_a_reg     <= a_slice[pick_id];
            m_b_reg     <= b_slice[pick_id];
            m_sign_reg  <= sgn[pick_id];
            m_start_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          m_start_reg <= 1'b0;
          state_reg   <= BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_reg     <= '0;
`endif
        end
        BUSY: begin
          if (m_valid) begin
            result_reg <= m_product;
            ack_reg    <= grant_onehot;
            state_reg  <= DONE;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
            ack_reg    <= grant_onehot;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
          err_reg   <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier and
// an expected-result queue consumed on every ack.
module tb_mult_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int LAT  = 9;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req = '0;
  logic [15:0]     op_a = '0;
  logic [15:0]     op_b = '0;
  logic [1:0]      sgn = '0;
  logic [1:0]      ack;
  logic [15:0]     result;
  logic            err;
  logic [0:0]      grant_id;
  logic            busy;
  logic            m_start;
  logic            m_sign;
  logic [7:0]      m_a;
  logic [7:0]      m_b;
  logic            m_valid;
  logic [15:0]     m_product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .sgn(sgn),
    .ack(ack), .result(result), .err(err), .grant_id(grant_id), .busy(busy),
    .m_start(m_start), .m_sign(m_sign), .m_a(m_a), .m_b(m_b),
    .m_valid(m_valid), .m_product(m_product)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: product appears LAT cycles after m_start.
  logic        mv_model = 1'b0;
  logic        spur = 1'b0;
  logic        mute = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] mprod_model = '0;

  assign m_valid   = mv_model | spur;
  assign m_product = mv_model ? mprod_model : 16'hDEAD;

  function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb2;
    if (s) begin
      sa  = {{8{a[7]}}, a};
      sb2 = {{8{b[7]}}, b};
      return 16'(sa * sb2);
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt  = 0;
      mv_model = 1'b0;
    end else begin
      #1;
      mv_model = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && !mute) mv_model = 1'b1;
      end
      if (m_start) begin
        lat_cnt     = LAT;
        mprod_model = mul(m_a, m_b, m_sign);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [15:0] r, input logic e);
    exp_t x;
    x.ack = a;
    x.res = r;
    x.err = e;
    sb.push_back(x);
  endtask

  // Wait (bounded) for an ack at a falling edge and compare with the queue head.
  task automatic expect_ack(input int budget);
    bit   found = 1'b0;
    exp_t x;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) found = 1'b1;
    end
    if (!found) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_ack", {30'd0, ack}, 32'd0);
    end else begin
      x = sb.pop_front();
      check("ack_vec", {30'd0, ack}, {30'd0, x.ack});
      check("result", {16'd0, result}, {16'd0, x.res});
      check("err", {31'd0, err}, {31'd0, x.err});
      $display("txn ack=%b result=%h err=%b", ack, result, err);
    end
  endtask

  // At most one requester may be acknowledged in any cycle.
  always @(negedge clk) begin
    if (reset && ack !== 2'b00) check("ack_onehot", {31'd0, $onehot(ack)}, 32'd1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_grant", {31'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mstart", {31'd0, m_start}, 32'd0);
    check("rst_msign", {31'd0, m_sign}, 32'd0);
    check("rst_ma", {24'd0, m_a}, 32'd0);
    check("rst_mb", {24'd0, m_b}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single unsigned request: 7*6
    op_a[7:0] = 8'd7; op_b[7:0] = 8'd6; sgn[0] = 1'b0; req = 2'b01;
    push_exp(2'b01, 16'd42, 1'b0);
    @(negedge clk);
    check("t1_mstart", {31'd0, m_start}, 32'd1);
    check("t1_ma", {24'd0, m_a}, 32'd7);
    check("t1_mb", {24'd0, m_b}, 32'd6);
    check("t1_msign", {31'd0, m_sign}, 32'd0);
    check("t1_grant", {31'd0, grant_id}, 32'd0);
    @(negedge clk);
    check("t1_mstart_drop", {31'd0, m_start}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    expect_ack(40);
    req = 2'b00;
    @(negedge clk);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Signed request on requester 1: -3*5
    op_a[15:8] = 8'hFD; op_b[15:8] = 8'd5; sgn[1] = 1'b1; req = 2'b10;
    push_exp(2'b10, 16'hFFF1, 1'b0);
    @(negedge clk);
    check("t2_msign", {31'd0, m_sign}, 32'd1);
    check("t2_grant", {31'd0, grant_id}, 32'd1);
    check("t2_ma", {24'd0, m_a}, 32'hFD);
    expect_ack(40);
    req = 2'b00;
    @(negedge clk);

    // Contention: both held, grants alternate 0,1,0,1
    op_a[7:0] = 8'd3; op_b[7:0] = 8'd4; sgn[0] = 1'b0;
    op_a[15:8] = 8'h80; op_b[15:8] = 8'h02; sgn[1] = 1'b1;
    req = 2'b11;
    push_exp(2'b01, 16'h000C, 1'b0);
    push_exp(2'b10, 16'hFF00, 1'b0);
    push_exp(2'b01, 16'h000C, 1'b0);
    push_exp(2'b10, 16'hFF00, 1'b0);
    for (int t = 0; t < 4; t++) expect_ack(40);
    req = 2'b00;
    @(negedge clk);

    // Spurious m_valid in IDLE must not capture
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("spur_idle_result", {16'd0, result}, 32'hFF00);
    check("spur_idle_ack", {30'd0, ack}, 32'd0);

    // Operand hold through BUSY, spurious m_valid in ISSUE ignored
    op_a[7:0] = 8'd9; op_b[7:0] = 8'd9; sgn[0] = 1'b0; req = 2'b01;
    push_exp(2'b01, 16'h0051, 1'b0);
    @(negedge clk);
    check("t4_mstart", {31'd0, m_start}, 32'd1);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd1);
    op_a[7:0] = 8'h55; sgn[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("t4_ma_hold", {24'd0, m_a}, 32'd9);
      check("t4_msign_hold", {31'd0, m_sign}, 32'd0);
    end
    expect_ack(40);
    req = 2'b00;
    @(negedge clk);

    // Reset in the middle of BUSY
    op_a[7:0] = 8'd2; op_b[7:0] = 8'd3; sgn[0] = 1'b0; req = 2'b01;
    repeat (3) @(negedge clk);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_mstart", {31'd0, m_start}, 32'd0);
    check("t5_ack", {30'd0, ack}, 32'd0);
    check("t5_result", {16'd0, result}, 32'd0);
    req = 2'b00;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_late_ack", {30'd0, ack}, 32'd0);

    // Fresh contention after reset: requester 0 first
    op_a[7:0] = 8'd5; op_b[7:0] = 8'd5; sgn[0] = 1'b0;
    op_a[15:8] = 8'hFF; op_b[15:8] = 8'hFF; sgn[1] = 1'b1;
    req = 2'b11;
    push_exp(2'b01, 16'h0019, 1'b0);
    push_exp(2'b10, 16'h0001, 1'b0);
    @(negedge clk);
    check("t5_first_grant", {31'd0, grant_id}, 32'd0);
    expect_ack(40);
    expect_ack(40);
    req = 2'b00;
    @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: no m_valid, abort after 16 BUSY cycles
    mute = 1'b1;
    op_a[7:0] = 8'd1; op_b[7:0] = 8'd1; sgn[0] = 1'b0; req = 2'b01;
    push_exp(2'b01, 16'h0000, 1'b1);
    @(negedge clk);
    check("t6_mstart", {31'd0, m_start}, 32'd1);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      check("t6_wait_noack", {30'd0, ack}, 32'd0);
    end
    expect_ack(1);
    req = 2'b00;
    mute = 1'b0;
    @(negedge clk);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
